mmc1_cpu_write_capture: RTL and testbench



---
 rtl/mmc1_cpu_write_capture.sv | 182 ++++++++++++++++++
 tb/tb_mmc1_cpu_write_capture.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mmc1_cpu_write_capture.sv
// MMC1 CPU write front end: synchronises the CPU bus and emits one CLK-domain strobe per completed $8000-$FFFF write.
// Optional MMC1_RMW_IGNORE_EN: reject the second write of a back-to-back pair (read-modify-write) via WR_DROP.
module mmc1_cpu_write_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_M2_HIGH = 3,
    parameter int CNT_W       = 4
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       CPU_M2,
    input  logic       nCPU_ROMSEL,
    input  logic       nCPU_RW,
    input  logic       CPU_A13,
    input  logic       CPU_A14,
    input  logic       CPU_D0,
    input  logic       CPU_D7,
    output logic       WR_STB,
    output logic [1:0] WR_SEL,
    output logic       WR_BIT,
    output logic       WR_CLR,
    output logic       WR_DROP,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, ARMED = 2'd2, EMIT = 2'd3} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_M2_HIGH);

    // Bus bit order: {D7, D0, A14, A13, R/W, /ROMSEL, M2}
    logic [6:0]             bus_raw;
    logic [6:0]             sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   m2_s, romsel_s, rw_s, m2_valid;
    logic [1:0]             a_s;
    logic                   d0_s, d7_s;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]       sh_sel, sh_sel_nxt;
    logic             sh_bit, sh_bit_nxt, sh_clr, sh_clr_nxt;
    logic             low_seen, low_seen_nxt;
    logic             emit_go, reject;

    assign bus_raw  = {CPU_D7, CPU_D0, CPU_A14, CPU_A13, nCPU_RW, nCPU_ROMSEL, CPU_M2};
    assign m2_s     = sync_q[SYNC_STAGES-1][0];
    assign romsel_s = sync_q[SYNC_STAGES-1][1];
    assign rw_s     = sync_q[SYNC_STAGES-1][2];
    assign a_s      = sync_q[SYNC_STAGES-1][4:3];
    assign d0_s     = sync_q[SYNC_STAGES-1][5];
    assign d7_s     = sync_q[SYNC_STAGES-1][6];
    assign m2_valid = vld_q[SYNC_STAGES-1];
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign fsm_state = state;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            vld_q <= '0;
        end else begin
            sync_q[0] <= bus_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

`ifdef MMC1_RMW_IGNORE_EN
    logic last_wr, last_wr_nxt;
    assign reject = last_wr;
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sh_sel_nxt   = sh_sel;
        sh_bit_nxt   = sh_bit;
        sh_clr_nxt   = sh_clr;
        // A rise only counts once M2 has been seen low through a filled chain,
        // so a pulse already high at reset release never qualifies.
        low_seen_nxt = low_seen | (m2_valid & ~m2_s);
        emit_go      = 1'b0;
`ifdef MMC1_RMW_IGNORE_EN
        last_wr_nxt  = last_wr;
`endif
        case (state)
            IDLE: begin
                if (m2_s && low_seen) begin
                    cnt_nxt      = CNT_W'(1);
                    low_seen_nxt = 1'b0;
                    state_nxt    = HIGH;
                end
            end
            HIGH: begin
                if (!m2_s) begin
                    state_nxt = IDLE;
`ifdef MMC1_RMW_IGNORE_EN
                    last_wr_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= MIN_CNT && !romsel_s && !rw_s) begin
                        state_nxt  = ARMED;
                        sh_sel_nxt = a_s;
                        sh_bit_nxt = d0_s;
                        sh_clr_nxt = d7_s;
                    end
                end
            end
            ARMED: begin
                if (!m2_s) begin
                    state_nxt = EMIT;
                    emit_go   = 1'b1;
`ifdef MMC1_RMW_IGNORE_EN
                    last_wr_nxt = ~last_wr;
`endif
                end else begin
                    cnt_nxt = cnt_inc;
                    if (romsel_s || rw_s) begin
                        state_nxt = HIGH;
                    end else begin
                        sh_sel_nxt = a_s;
                        sh_bit_nxt = d0_s;
                        sh_clr_nxt = d7_s;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            cnt      <= '0;
            sh_sel   <= '0;
            sh_bit   <= 1'b0;
            sh_clr   <= 1'b0;
            low_seen <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sh_sel   <= sh_sel_nxt;
            sh_bit   <= sh_bit_nxt;
            sh_clr   <= sh_clr_nxt;
            low_seen <= low_seen_nxt;
        end
    end

    // Outputs are registered on entry to EMIT so the strobe spans exactly the EMIT cycle.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            WR_STB <= 1'b0;
            WR_SEL <= '0;
            WR_BIT <= 1'b0;
            WR_CLR <= 1'b0;
        end else begin
            WR_STB <= emit_go & ~reject;
            if (emit_go) begin
                WR_SEL <= sh_sel;
                WR_BIT <= sh_bit;
                WR_CLR <= sh_clr;
            end
        end
    end

`ifdef MMC1_RMW_IGNORE_EN
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            WR_DROP <= 1'b0;
            last_wr <= 1'b0;
        end else begin
            WR_DROP <= emit_go & reject;
            last_wr <= last_wr_nxt;
        end
    end
`else
    assign WR_DROP = 1'b0;
`endif

endmodule

// File: tb/tb_mmc1_cpu_write_capture.sv
// Self-checking bench for mmc1_cpu_write_capture: scoreboard of expected strobes/drops driven by CPU bus cycles.
module tb_mmc1_cpu_write_capture;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A13, CPU_A14, CPU_D0, CPU_D7;
    logic       WR_STB, WR_BIT, WR_CLR, WR_DROP;
    logic [1:0] WR_SEL, fsm_state;

    // Scoreboard entry: {drop, sel[1:0], bit, clr}
    logic [4:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_evt = 0;
    int         n_exp = 0;
    logic       m_last_wr = 1'b0;

    mmc1_cpu_write_capture dut (
        .CLK(CLK), .nRESET(nRESET), .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL),
        .nCPU_RW(nCPU_RW), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14), .CPU_D0(CPU_D0),
        .CPU_D7(CPU_D7), .WR_STB(WR_STB), .WR_SEL(WR_SEL), .WR_BIT(WR_BIT),
        .WR_CLR(WR_CLR), .WR_DROP(WR_DROP), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stb"}, WR_STB, 0);
        check({tag, "_sel"}, WR_SEL, 0);
        check({tag, "_bit"}, WR_BIT, 0);
        check({tag, "_clr"}, WR_CLR, 0);
        check({tag, "_drop"}, WR_DROP, 0);
        check({tag, "_state"}, fsm_state, 0);
    endtask

    // One CPU bus cycle; entered and left at posedge+3.
    task automatic bus_cycle(input logic [15:0] addr, input logic [7:0] data, input logic rw,
                             input int hi, input int lo);
        logic qual, acc, drop;
        qual = !rw && addr[15] && (hi >= 3);
        acc  = 1'b0;
        drop = 1'b0;
        if (qual) begin
`ifdef MMC1_RMW_IGNORE_EN
            if (m_last_wr) begin drop = 1'b1; m_last_wr = 1'b0; end
            else begin acc = 1'b1; m_last_wr = 1'b1; end
`else
            acc = 1'b1;
`endif
            exp_q.push_back({drop, addr[14:13], data[0], data[7]});
            n_exp++;
        end else begin
            m_last_wr = 1'b0;
        end
        CPU_A13 = addr[13];
        CPU_A14 = addr[14];
        CPU_D0  = data[0];
        CPU_D7  = data[7];
        nCPU_RW = rw;
        CPU_M2  = 1'b1;
        nCPU_ROMSEL = ~addr[15];
        repeat (hi) @(posedge CLK);
        #3;
        CPU_M2 = 1'b0;
        nCPU_ROMSEL = 1'b1;
        if (qual) begin
            repeat (2) @(posedge CLK);
            #1 check("early_evt", {WR_STB, WR_DROP}, 0);
            @(posedge CLK);
            #1 check("latency_evt", {WR_STB, WR_DROP}, {acc, drop});
            #2;
            repeat (lo - 3) @(posedge CLK);
            #3;
        end else begin
            repeat (lo) @(posedge CLK);
            #3;
        end
    endtask

    always @(negedge CLK) begin
        if (nRESET) begin
            if (WR_STB && WR_DROP) check("stb_and_drop", 1, 0);
            if (WR_STB || WR_DROP) begin
                n_evt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_evt", {WR_STB, WR_DROP}, 0);
                end else begin
                    check("evt_fields", {WR_DROP, WR_SEL, WR_BIT, WR_CLR}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        nRESET = 1'b0;
        CPU_M2 = 1'b0; nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
        CPU_A13 = 1'b0; CPU_A14 = 1'b0; CPU_D0 = 1'b0; CPU_D7 = 1'b0;
        repeat (3) @(posedge CLK);
        #1 check_idle_outputs("reset");
        #2 nRESET = 1'b1;
        repeat (4) @(posedge CLK);
        #3;

        // $8000 D=$80 then a read to clear the back-to-back history
        bus_cycle(16'h8000, 8'h80, 1'b0, 12, 8);
        bus_cycle(16'h8000, 8'h00, 1'b1, 12, 8);

        // $E000 D=$01 then a read: fields must hold through the read
        bus_cycle(16'hE000, 8'h01, 1'b0, 12, 8);
        bus_cycle(16'hE000, 8'hFE, 1'b1, 12, 8);
        check("hold_sel", WR_SEL, 2'b11);
        check("hold_bit", WR_BIT, 1'b1);
        check("hold_clr", WR_CLR, 1'b0);

        // Two-sample glitch is filtered; exactly three samples qualify
        bus_cycle(16'h8000, 8'h80, 1'b0, 2, 8);
        check("glitch_idle", fsm_state, 0);
        bus_cycle(16'hA000, 8'h01, 1'b0, 3, 8);
        bus_cycle(16'hA000, 8'h00, 1'b1, 6, 8);

        // Back-to-back $A000 writes
        bus_cycle(16'hA000, 8'h01, 1'b0, 10, 6);
        bus_cycle(16'hA000, 8'h00, 1'b0, 10, 6);
        bus_cycle(16'hA000, 8'h00, 1'b1, 10, 6);

        // $C000, idle read, $C000
        bus_cycle(16'hC000, 8'h01, 1'b0, 10, 8);
        bus_cycle(16'hC000, 8'h00, 1'b1, 10, 8);
        bus_cycle(16'hC000, 8'h80, 1'b0, 10, 8);

        // Reset pulsed in the middle of a write's M2 high phase
        CPU_A13 = 1'b0; CPU_A14 = 1'b0; CPU_D0 = 1'b1; CPU_D7 = 1'b1;
        nCPU_RW = 1'b0; CPU_M2 = 1'b1; nCPU_ROMSEL = 1'b0;
        repeat (5) @(posedge CLK);
        #3 nRESET = 1'b0;
        #1 check_idle_outputs("mid_reset");
        m_last_wr = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #3 nRESET = 1'b1;
        repeat (6) @(posedge CLK);
        #3 CPU_M2 = 1'b0; nCPU_ROMSEL = 1'b1;
        repeat (10) @(posedge CLK);
        #3;
        check("post_reset_stb", WR_STB, 0);
        check("post_reset_state", fsm_state, 0);
        bus_cycle(16'h8000, 8'h80, 1'b0, 12, 8);

        // Random bus traffic
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  top;
            logic [7:0]  d;
            top = 3'($urandom_range(0, 7));
            d   = 8'($urandom_range(0, 255));
            bus_cycle({top, 13'h0}, d, 1'($urandom_range(0, 1)),
                      $urandom_range(1, 12), $urandom_range(6, 10));
        end

        repeat (20) @(posedge CLK);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("evt_count", n_evt, n_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
